// File: rtl/bfm_ahbarbiter_if.sv
// bfm_ahbarbiter_if: arbitration signals shared by the BFM masters, the bridge and bfm_ahbarbiter.
interface bfm_ahbarbiter_if;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic       HRESP;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/bfm_ahbarbiter.sv
// bfm_ahbarbiter: classic AHB arbiter for up to 4 BFM masters with burst/lock hold and default parking.
// Build macro BFM_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module bfm_ahbarbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int TPD            = 1
) (
  input logic             HCLK,
  input logic             HRESET,
  bfm_ahbarbiter_if.slave bus
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] DEF_IDX  = 2'(DEFAULT_MASTER);
  localparam logic [3:0] REQ_MASK = 4'((1 << NUM_MASTERS) - 1);

  // Outputs leave straight from flops; TPD only matters to delay-annotated behavioural models.
  if (TPD < 0) begin : g_tpd_negative
  end

  logic [3:0] grant_q;
  logic [1:0] master_q;
  logic       mastlock_q;
  logic [3:0] rem_q;
  logic [3:0] rem_next;
  logic [1:0] cur_idx;
  logic [3:0] req_valid;
  logic       hold;
  logic       arb_found;
  logic [1:0] arb_winner;
  htrans_e    trans;

  assign trans     = htrans_e'(bus.HTRANS);
  assign req_valid = bus.HBUSREQ & REQ_MASK;

  always_comb begin
    cur_idx = DEF_IDX;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) cur_idx = 2'(i);
    end
  end

  // An error response kills the burst count even while HREADY is low.
  always_comb begin
    rem_next = rem_q;
    if (bus.HREADY) begin
      case (trans)
        TRANS_NONSEQ: begin
          case (bus.HBURST)
            3'b010, 3'b011: rem_next = 4'd3;
            3'b100, 3'b101: rem_next = 4'd7;
            3'b110, 3'b111: rem_next = 4'd15;
            default:        rem_next = 4'd0;
          endcase
        end
        TRANS_SEQ:  rem_next = (rem_q == 4'd0) ? 4'd0 : rem_q - 4'd1;
        TRANS_IDLE: rem_next = 4'd0;
        default:    rem_next = rem_q;
      endcase
    end
    if (bus.HRESP) rem_next = 4'd0;
  end

  // Releasing at rem_next == 1 lets the next owner's address phase follow the final beat.
  assign hold = (rem_next >= 4'd2) || (bus.HLOCK[cur_idx] && bus.HBUSREQ[cur_idx]);

`ifdef BFM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = DEF_IDX;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        arb_found  = 1'b1;
        arb_winner = 2'(i);
      end
    end
  end
`else
  logic [1:0] rr_ptr_q;
  logic [1:0] cand;

  always_comb begin
    arb_found  = 1'b0;
    arb_winner = DEF_IDX;
    cand       = rr_ptr_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = 2'((int'(rr_ptr_q) + i) % NUM_MASTERS);
      if (!arb_found && req_valid[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rr_ptr_q <= DEF_IDX;
    end else if (bus.HREADY && !hold && arb_found) begin
      rr_ptr_q <= arb_winner;
    end
  end
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q    <= 4'b0001 << DEF_IDX;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      rem_q      <= 4'd0;
    end else begin
      rem_q <= rem_next;
      if (bus.HREADY) begin
        master_q   <= cur_idx;
        mastlock_q <= bus.HLOCK[cur_idx];
        if (!hold) begin
          grant_q <= 4'b0001 << (arb_found ? arb_winner : DEF_IDX);
        end
      end
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = master_q;
  assign bus.HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_bfm_ahbarbiter.sv
// tb_bfm_ahbarbiter: directed checks of reset, rotation, burst/lock hold, error abort and parking.
module tb_bfm_ahbarbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy;
    logic       rsp;
    logic [3:0] g;
    logic [1:0] m;
    logic       ml;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bfm_ahbarbiter_if bus ();
  bfm_ahbarbiter_if bus_p ();

  bfm_ahbarbiter dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  bfm_ahbarbiter #(.DEFAULT_MASTER(2)) dut_p (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus_p.slave)
  );

  assign bus_p.HBUSREQ = bus.HBUSREQ;
  assign bus_p.HLOCK   = bus.HLOCK;
  assign bus_p.HTRANS  = bus.HTRANS;
  assign bus_p.HBURST  = bus.HBURST;
  assign bus_p.HREADY  = bus.HREADY;
  assign bus_p.HRESP   = bus.HRESP;

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic rsp);
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    bus.HRESP   = rsp;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_g [5];
    logic [1:0] exp_m [5];
`ifdef BFM_ARB_FIXED_PRIORITY_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_m = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_m = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    rst = 1'b1;
    drive(4'b1111, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    drive(4'b1111, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    total++;
    if (bus.HGRANT !== 4'b0001) begin
      bad++; $display("[TB] FAIL reset_grant: got %b want 0001", bus.HGRANT);
    end
    total++;
    if (bus.HMASTER !== 2'd0) begin
      bad++; $display("[TB] FAIL reset_master: got %0d want 0", bus.HMASTER);
    end
    total++;
    if (bus.HMASTLOCK !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mastlock: got %b want 0", bus.HMASTLOCK);
    end
    total++;
    if (bus_p.HGRANT !== 4'b0100) begin
      bad++; $display("[TB] FAIL reset_park_grant: got %b want 0100", bus_p.HGRANT);
    end
    total++;
    if (bus_p.HMASTER !== 2'd2) begin
      bad++; $display("[TB] FAIL reset_park_master: got %0d want 2", bus_p.HMASTER);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
      total++;
      if (bus.HGRANT !== exp_g[k]) begin
        bad++; $display("[TB] FAIL rotate_grant[%0d]: got %b want %b", k, bus.HGRANT, exp_g[k]);
      end
      total++;
      if (bus.HMASTER !== exp_m[k]) begin
        bad++; $display("[TB] FAIL rotate_master[%0d]: got %0d want %0d", k, bus.HMASTER, exp_m[k]);
      end
    end
  endtask

  task automatic test_burst_hold();
    vec_t tbl [7];
    tbl = '{
      '{4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0},
      '{4'b0110, 4'b0000, T_NONSEQ, B_INCR4,  1'b1, 1'b0, 4'b0100, 2'd2, 1'b0},
      '{4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b0, 1'b0, 4'b0100, 2'd2, 1'b0},
      '{4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 1'b0, 4'b0100, 2'd2, 1'b0},
      '{4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1'b0, 1'b0, 4'b0100, 2'd2, 1'b0},
      '{4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 1'b0, 4'b0010, 2'd2, 1'b0},
      '{4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1'b0, 1'b0, 4'b0010, 2'd2, 1'b0}
    };
    drive(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(tbl[k].req, tbl[k].lock, tbl[k].tr, tbl[k].bu, tbl[k].rdy, tbl[k].rsp);
      total++;
      if (bus.HGRANT !== tbl[k].g) begin
        bad++; $display("[TB] FAIL burst_grant[%0d]: got %b want %b", k, bus.HGRANT, tbl[k].g);
      end
      total++;
      if (bus.HMASTER !== tbl[k].m) begin
        bad++; $display("[TB] FAIL burst_master[%0d]: got %0d want %0d", k, bus.HMASTER, tbl[k].m);
      end
    end
    drive(4'b0010, 4'b0000, T_SEQ, B_INCR4, 1'b1, 1'b0);
    total++;
    if (bus.HMASTER !== 2'd1) begin
      bad++; $display("[TB] FAIL burst_last_beat_master: got %0d want 1", bus.HMASTER);
    end
    total++;
    if (bus.HGRANT !== 4'b0010) begin
      bad++; $display("[TB] FAIL burst_last_beat_grant: got %b want 0010", bus.HGRANT);
    end
  endtask

  task automatic test_lock();
    vec_t tbl [7];
    tbl = '{
      '{4'b1000, 4'b1000, T_IDLE,   B_SINGLE, 1'b1, 1'b0, 4'b1000, 2'd1, 1'b0},
      '{4'b1111, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1},
      '{4'b1111, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1},
      '{4'b1111, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1},
      '{4'b1111, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1},
      '{4'b1111, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1},
      '{4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0}
    };
    for (int k = 0; k < 7; k++) begin
      drive(tbl[k].req, tbl[k].lock, tbl[k].tr, tbl[k].bu, tbl[k].rdy, tbl[k].rsp);
      total++;
      if (bus.HGRANT !== tbl[k].g) begin
        bad++; $display("[TB] FAIL lock_grant[%0d]: got %b want %b", k, bus.HGRANT, tbl[k].g);
      end
      total++;
      if (bus.HMASTER !== tbl[k].m) begin
        bad++; $display("[TB] FAIL lock_master[%0d]: got %0d want %0d", k, bus.HMASTER, tbl[k].m);
      end
      total++;
      if (bus.HMASTLOCK !== tbl[k].ml) begin
        bad++; $display("[TB] FAIL lock_mastlock[%0d]: got %b want %b", k, bus.HMASTLOCK, tbl[k].ml);
      end
    end
  endtask

  task automatic test_error_abort();
    vec_t tbl [5];
    tbl = '{
      '{4'b0001, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0},
      '{4'b0011, 4'b0000, T_NONSEQ, B_INCR8,  1'b1, 1'b0, 4'b0001, 2'd0, 1'b0},
      '{4'b0011, 4'b0000, T_SEQ,    B_INCR8,  1'b1, 1'b0, 4'b0001, 2'd0, 1'b0},
      '{4'b0011, 4'b0000, T_SEQ,    B_INCR8,  1'b0, 1'b1, 4'b0001, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, T_SEQ,    B_INCR8,  1'b1, 1'b1, 4'b0010, 2'd0, 1'b0}
    };
    for (int k = 0; k < 5; k++) begin
      drive(tbl[k].req, tbl[k].lock, tbl[k].tr, tbl[k].bu, tbl[k].rdy, tbl[k].rsp);
      total++;
      if (bus.HGRANT !== tbl[k].g) begin
        bad++; $display("[TB] FAIL error_grant[%0d]: got %b want %b", k, bus.HGRANT, tbl[k].g);
      end
      total++;
      if (bus.HMASTER !== tbl[k].m) begin
        bad++; $display("[TB] FAIL error_master[%0d]: got %0d want %0d", k, bus.HMASTER, tbl[k].m);
      end
    end
  endtask

  task automatic test_park();
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    total++;
    if (bus.HGRANT !== 4'b0001) begin
      bad++; $display("[TB] FAIL park_grant: got %b want 0001", bus.HGRANT);
    end
    total++;
    if (bus.HMASTER !== 2'd1) begin
      bad++; $display("[TB] FAIL park_master: got %0d want 1", bus.HMASTER);
    end
    total++;
    if (bus_p.HGRANT !== 4'b0100) begin
      bad++; $display("[TB] FAIL park2_grant: got %b want 0100", bus_p.HGRANT);
    end
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    total++;
    if (bus_p.HMASTER !== 2'd2) begin
      bad++; $display("[TB] FAIL park2_master: got %0d want 2", bus_p.HMASTER);
    end
    for (int k = 0; k < 10; k++) begin
      drive(4'(k + 1), 4'(k), T_NONSEQ, B_INCR4, 1'b0, 1'b0);
      total++;
      if (bus.HGRANT !== 4'b0001 || bus.HMASTER !== 2'd0 || bus.HMASTLOCK !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: got grant=%b master=%0d lock=%b want 0001/0/0",
                 k, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
      end
      total++;
      if (bus_p.HGRANT !== 4'b0100 || bus_p.HMASTER !== 2'd2 || bus_p.HMASTLOCK !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold_p[%0d]: got grant=%b master=%0d lock=%b want 0100/2/0",
                 k, bus_p.HGRANT, bus_p.HMASTER, bus_p.HMASTLOCK);
      end
    end
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    drive(4'b0001, 4'b0000, T_NONSEQ, B_INCR16, 1'b1, 1'b0);
    total++;
    if (bus.HGRANT !== 4'b0001) begin
      bad++; $display("[TB] FAIL midburst_start_grant: got %b want 0001", bus.HGRANT);
    end
    rst = 1'b1;
    drive(4'b0011, 4'b0000, T_SEQ, B_INCR16, 1'b0, 1'b0);
    rst = 1'b0;
    total++;
    if (bus.HGRANT !== 4'b0001 || bus.HMASTER !== 2'd0) begin
      bad++; $display("[TB] FAIL midburst_reset: got grant=%b master=%0d want 0001/0", bus.HGRANT, bus.HMASTER);
    end
    // BUSY leaves rem alone, so a surviving count would keep master 0 granted here.
    drive(4'b0010, 4'b0000, T_BUSY, B_INCR16, 1'b1, 1'b0);
    total++;
    if (bus.HGRANT !== 4'b0010) begin
      bad++; $display("[TB] FAIL midburst_rem_cleared: got %b want 0010", bus.HGRANT);
    end
  endtask

  task automatic test_two_requesters();
    logic [3:0] exp_g;
    logic [1:0] exp_m;
    for (int k = 0; k < 6; k++) begin
`ifdef BFM_ARB_FIXED_PRIORITY_EN
      exp_g = 4'b0010;
      exp_m = 2'd1;
`else
      exp_g = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      exp_m = (k % 2 == 0) ? 2'd1 : 2'd3;
`endif
      drive(4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
      total++;
      if (bus.HGRANT !== exp_g) begin
        bad++; $display("[TB] FAIL pair_grant[%0d]: got %b want %b", k, bus.HGRANT, exp_g);
      end
      total++;
      if (bus.HMASTER !== exp_m) begin
        bad++; $display("[TB] FAIL pair_master[%0d]: got %0d want %0d", k, bus.HMASTER, exp_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst_hold();
    test_lock();
    test_error_abort();
    test_park();
    test_reset_mid_burst();
    test_two_requesters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
